branch_target_predictor: RTL and testbench

- Parametrised, stateful successor to the decode-stage branch detection/target generation in the ID stage.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, indexed by fetch PC.
- Returns a registered prediction (taken, absolute target) one cycle after lookup.
- Trained by resolved-branch updates from execute; sits beside the IF stage PC mux.

---
 rtl/branch_target_predictor.sv | 123 ++++++++++++
 tb/tb_branch_target_predictor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; registered prediction one cycle after lookup.
// Optional perf counters (lookups, hits, mispredicts) are built when BP_PERF_CNT_EN is defined.
module branch_target_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 64,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_branch,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
`ifdef BP_PERF_CNT_EN
  input  logic                  upd_mispredict,
  output logic [31:0]           perf_lookups,
  output logic [31:0]           perf_hits,
  output logic [31:0]           perf_mispredicts
`else
  input  logic                  upd_mispredict
`endif
);
  localparam int INDEX_WIDTH = $clog2(ENTRIES);
  localparam int TAG_LO      = INDEX_WIDTH + 2;
  localparam int TAG_HI      = INDEX_WIDTH + TAG_WIDTH + 1;

  logic [ENTRIES-1:0]                 ent_valid;
  logic [ENTRIES-1:0][TAG_WIDTH-1:0]  ent_tag;
  logic [ENTRIES-1:0][ADDR_WIDTH-1:0] ent_target;
  logic [ENTRIES-1:0][1:0]            ent_ctr;

  logic [INDEX_WIDTH-1:0] lk_idx, up_idx;
  logic [TAG_WIDTH-1:0]   lk_tag, up_tag;
  logic                   lk_hit, lk_taken, up_hit;
  logic [ADDR_WIDTH-1:0]  lk_next;

  assign lk_idx   = lookup_pc[INDEX_WIDTH+1:2];
  assign lk_tag   = lookup_pc[TAG_HI:TAG_LO];
  assign up_idx   = upd_pc[INDEX_WIDTH+1:2];
  assign up_tag   = upd_pc[TAG_HI:TAG_LO];
  assign lk_hit   = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ent_ctr[lk_idx][1];
  assign up_hit   = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);
  assign lk_next  = lk_taken ? ent_target[lk_idx] : lookup_pc + ADDR_WIDTH'(4);

  // Low PC bits, bits above the tag and (default build) upd_mispredict carry no information here.
  logic unused_ok;
  assign unused_ok = ^{lookup_pc, upd_pc, upd_mispredict};

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (flush) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (!stall) begin
      pred_valid  <= lookup_valid;
      pred_hit    <= lookup_valid && lk_hit;
      pred_taken  <= lookup_valid && lk_taken;
      pred_target <= lookup_valid ? lk_next : '0;
    end
  end

  // Training; lookups in the same cycle see the pre-update contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid  <= '0;
      ent_tag    <= '0;
      ent_target <= '0;
      ent_ctr    <= '0;
    end else if (upd_valid) begin
      if (upd_is_branch) begin
        if (up_hit) begin
          if (upd_taken) begin
            ent_target[up_idx] <= upd_target;
            if (ent_ctr[up_idx] != 2'b11) ent_ctr[up_idx] <= ent_ctr[up_idx] + 2'b01;
          end else if (ent_ctr[up_idx] != 2'b00) begin
            ent_ctr[up_idx] <= ent_ctr[up_idx] - 2'b01;
          end
        end else if (upd_taken) begin
          ent_valid[up_idx]  <= 1'b1;
          ent_tag[up_idx]    <= up_tag;
          ent_target[up_idx] <= upd_target;
          ent_ctr[up_idx]    <= 2'b10;
        end
      end else if (up_hit) begin
        ent_valid[up_idx] <= 1'b0;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic lk_accept;
  assign lk_accept = lookup_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lookups     <= '0;
      perf_hits        <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (lk_accept)                 perf_lookups     <= perf_lookups + 32'd1;
      if (lk_accept && lk_hit)       perf_hits        <= perf_hits + 32'd1;
      if (upd_valid && upd_mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: hand-computed vectors, one task per scenario.
module tb_branch_target_predictor;
  logic        clk = 1'b0;
  logic        rst, lookup_valid, stall, flush;
  logic [31:0] lookup_pc;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_branch, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_lookups, perf_hits, perf_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  logic [34:0] obs;
  assign obs = {pred_valid, pred_hit, pred_taken, pred_target};

  always #5 clk = ~clk;

  branch_target_predictor dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .stall(stall), .flush(flush), .pred_valid(pred_valid), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
    .upd_target(upd_target),
`ifdef BP_PERF_CNT_EN
    .upd_mispredict(upd_mispredict), .perf_lookups(perf_lookups),
    .perf_hits(perf_hits), .perf_mispredicts(perf_mispredicts)
`else
    .upd_mispredict(upd_mispredict)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_valid = 1'b1; lookup_pc = pc;
    step();
    lookup_valid = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic br, input logic tk,
                           input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_taken = tk; upd_target = tgt;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0; stall = 1'b0; flush = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_is_branch = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0;
    step(); step();
    rst = 1'b0;
    total++;
    if (obs !== 35'h0) begin bad++; $display("FAIL reset: got %h exp %h", obs, 35'h0); end
  endtask

  task automatic test_miss();
    do_lookup(32'h00400010);
    total++;
    if (obs !== {3'b100, 32'h00400014}) begin
      bad++; $display("FAIL cold_miss: got %h exp %h", obs, {3'b100, 32'h00400014});
    end
  endtask

  task automatic test_train();
    do_update(32'h00400010, 1'b1, 1'b1, 32'h00400100);
    do_lookup(32'h00400010);
    total++;
    if (obs !== {3'b111, 32'h00400100}) begin
      bad++; $display("FAIL alloc_hit: got %h exp %h", obs, {3'b111, 32'h00400100});
    end
  endtask

  task automatic test_saturate();
    // 10 -> 01 -> 00; not-taken updates must not touch the stored target
    do_update(32'h00400010, 1'b1, 1'b0, 32'h00400300);
    do_update(32'h00400010, 1'b1, 1'b0, 32'h00400300);
    do_lookup(32'h00400010);
    total++;
    if (obs !== {3'b110, 32'h00400014}) begin
      bad++; $display("FAIL ctr_down: got %h exp %h", obs, {3'b110, 32'h00400014});
    end
    do_update(32'h00400010, 1'b1, 1'b0, 32'h00400300);
    do_lookup(32'h00400010);
    total++;
    if (obs !== {3'b110, 32'h00400014}) begin
      bad++; $display("FAIL ctr_sat_low: got %h exp %h", obs, {3'b110, 32'h00400014});
    end
    // 00 -> 01 -> 10 -> 11 -> 11, last taken update retargets
    for (int i = 0; i < 4; i++)
      do_update(32'h00400010, 1'b1, 1'b1, (i == 3) ? 32'h00400200 : 32'h00400100);
    do_update(32'h00400010, 1'b1, 1'b0, 32'h00400300);
    do_lookup(32'h00400010);
    total++;
    if (obs !== {3'b111, 32'h00400200}) begin
      bad++; $display("FAIL ctr_sat_high: got %h exp %h", obs, {3'b111, 32'h00400200});
    end
    do_update(32'h00400010, 1'b1, 1'b0, 32'h00400300);
    do_lookup(32'h00400010);
    total++;
    if (obs !== {3'b110, 32'h00400014}) begin
      bad++; $display("FAIL ctr_weak_nt: got %h exp %h", obs, {3'b110, 32'h00400014});
    end
  endtask

  task automatic test_alias();
    do_lookup(32'h00401010);
    total++;
    if (obs !== {3'b100, 32'h00401014}) begin
      bad++; $display("FAIL alias_miss: got %h exp %h", obs, {3'b100, 32'h00401014});
    end
    do_update(32'h00400010, 1'b0, 1'b0, 32'h0);
    do_lookup(32'h00400010);
    total++;
    if (obs !== {3'b100, 32'h00400014}) begin
      bad++; $display("FAIL invalidate: got %h exp %h", obs, {3'b100, 32'h00400014});
    end
    do_update(32'h00400030, 1'b1, 1'b0, 32'h00400500);
    do_lookup(32'h00400030);
    total++;
    if (obs !== {3'b100, 32'h00400034}) begin
      bad++; $display("FAIL nt_no_alloc: got %h exp %h", obs, {3'b100, 32'h00400034});
    end
  endtask

  task automatic test_same_cycle();
    lookup_valid = 1'b1; lookup_pc = 32'h00400020;
    upd_valid = 1'b1; upd_pc = 32'h00400020; upd_is_branch = 1'b1; upd_taken = 1'b1;
    upd_target = 32'h00400400;
    step();
    upd_valid = 1'b0;
    total++;
    if (obs !== {3'b100, 32'h00400024}) begin
      bad++; $display("FAIL same_cycle_old: got %h exp %h", obs, {3'b100, 32'h00400024});
    end
    step();
    lookup_valid = 1'b0;
    total++;
    if (obs !== {3'b111, 32'h00400400}) begin
      bad++; $display("FAIL same_cycle_new: got %h exp %h", obs, {3'b111, 32'h00400400});
    end
  endtask

  task automatic test_stall_flush();
    stall = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h00400010;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs !== {3'b111, 32'h00400400}) begin
        bad++; $display("FAIL stall_hold%0d: got %h exp %h", i, obs, {3'b111, 32'h00400400});
      end
    end
    flush = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0; lookup_valid = 1'b0;
    total++;
    if (obs !== 35'h0) begin bad++; $display("FAIL flush_stall: got %h exp %h", obs, 35'h0); end
    do_lookup(32'h00400020);
    step();
    total++;
    if (obs !== 35'h0) begin bad++; $display("FAIL idle_clear: got %h exp %h", obs, 35'h0); end
  endtask

  task automatic test_wrap();
    do_lookup(32'hFFFFFFFC);
    total++;
    if (obs !== {3'b100, 32'h00000000}) begin
      bad++; $display("FAIL pc_wrap: got %h exp %h", obs, {3'b100, 32'h00000000});
    end
  endtask

  task automatic test_reset_mid();
    do_update(32'h00400010, 1'b1, 1'b1, 32'h00400100);
    lookup_valid = 1'b1; lookup_pc = 32'h00400010;
    upd_valid = 1'b1; upd_pc = 32'h00400040; upd_is_branch = 1'b1; upd_taken = 1'b1;
    upd_target = 32'h00400600; rst = 1'b1;
    step();
    rst = 1'b0; upd_valid = 1'b0; lookup_valid = 1'b0;
    total++;
    if (obs !== 35'h0) begin bad++; $display("FAIL mid_reset: got %h exp %h", obs, 35'h0); end
    do_lookup(32'h00400010);
    total++;
    if (obs !== {3'b100, 32'h00400014}) begin
      bad++; $display("FAIL rst_clear_a: got %h exp %h", obs, {3'b100, 32'h00400014});
    end
    do_lookup(32'h00400020);
    total++;
    if (obs !== {3'b100, 32'h00400024}) begin
      bad++; $display("FAIL rst_clear_b: got %h exp %h", obs, {3'b100, 32'h00400024});
    end
    do_lookup(32'h00400040);
    total++;
    if (obs !== {3'b100, 32'h00400044}) begin
      bad++; $display("FAIL rst_drop_upd: got %h exp %h", obs, {3'b100, 32'h00400044});
    end
  endtask

`ifdef BP_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1; step(); rst = 1'b0;
    total++;
    if ({perf_lookups, perf_hits, perf_mispredicts} !== 96'h0) begin
      bad++; $display("FAIL perf_reset: got %0d/%0d/%0d exp 0/0/0",
                      perf_lookups, perf_hits, perf_mispredicts);
    end
    do_update(32'h00400050, 1'b1, 1'b1, 32'h00400700);
    do_lookup(32'h00400050);
    do_lookup(32'h00400050);
    do_lookup(32'h00400060);
    do_lookup(32'h00400070);
    do_lookup(32'h00400080);
    stall = 1'b1; do_lookup(32'h00400050); stall = 1'b0;
    flush = 1'b1; do_lookup(32'h00400050); flush = 1'b0;
    upd_mispredict = 1'b1;
    do_update(32'h00400060, 1'b1, 1'b0, 32'h0);
    upd_mispredict = 1'b0;
    total++;
    if ({perf_lookups, perf_hits, perf_mispredicts} !== {32'd5, 32'd2, 32'd1}) begin
      bad++; $display("FAIL perf_counts: got %0d/%0d/%0d exp 5/2/1",
                      perf_lookups, perf_hits, perf_mispredicts);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_miss();
    test_train();
    test_saturate();
    test_alias();
    test_same_cycle();
    test_stall_flush();
    test_wrap();
    test_reset_mid();
`ifdef BP_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
